// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit.
// Holds the funct3 codes, the FSM state type and the legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        FAULT
    } lsu_state_t;

    // Unsigned widths exist only for loads; alignment follows access size.
    function automatic logic req_legal(
        input logic       we,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = ~we;
            F3_HU:   ok = ~we & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, and lane merge
// of the store byte/half into the word read back for read-modify-write.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{offset_i, 3'b000} +: 8];
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        load_o = 32'h0;
        case (funct3_i)
            F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_o = word_i;
            F3_BU:   load_o = {24'h0, byte_sel};
            F3_HU:   load_o = {16'h0, half_sel};
            default: load_o = 32'h0;
        endcase
    end

    always_comb begin
        store_o = word_i;
        case (funct3_i)
            F3_B: store_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
            F3_H: begin
                if (offset_i[1]) store_o[31:16] = wdata_i[15:0];
                else             store_o[15:0]  = wdata_i[15:0];
            end
            default: store_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit bridging byte-addressed RV32I accesses to a word-only
// memory; sub-word stores are done as read-modify-write.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              d_we,
    output logic [ADDR_W-1:0] daddr,
    output logic [31:0]       dwdata,
    input  logic [31:0]       drdata
);

    lsu_state_t state_q, state_d;

    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       dwdata_q, dwdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rv_q, rv_d;
    logic              err_q, err_d;

    logic [31:0] load_val;
    logic [31:0] store_word;
    logic        unused_addr_hi;

    // Byte address bits above the word index are ignored.
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    lsu_align u_align (
        .word_i   (drdata),
        .offset_i (addr_q[1:0]),
        .funct3_i (f3_q),
        .wdata_i  (wdata_q),
        .load_o   (load_val),
        .store_o  (store_word)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        f3_d     = f3_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        dwdata_d = dwdata_q;
        rdata_d  = rdata_q;
        rv_d     = 1'b0;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr[ADDR_W+1:0];
                    f3_d    = req_funct3;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    if (!req_legal(req_we, req_funct3, req_addr[1:0])) begin
                        state_d = FAULT;
                    end else if (req_we && req_funct3 == F3_W) begin
                        dwdata_d = req_wdata;
                        state_d  = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (we_q) begin
                    dwdata_d = store_word;
                    state_d  = WRITE;
                end else begin
                    rdata_d = load_val;
                    err_d   = 1'b0;
                    rv_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                rdata_d = 32'h0;
                err_d   = 1'b0;
                rv_d    = 1'b1;
                state_d = IDLE;
            end
            FAULT: begin
                rdata_d = 32'h0;
                err_d   = 1'b1;
                rv_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            f3_q     <= 3'b000;
            we_q     <= 1'b0;
            wdata_q  <= 32'h0;
            dwdata_q <= 32'h0;
            rdata_q  <= 32'h0;
            rv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            f3_q     <= f3_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            dwdata_q <= dwdata_d;
            rdata_q  <= rdata_d;
            rv_q     <= rv_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign d_we       = (state_q == WRITE);
    assign daddr      = addr_q[ADDR_W+1:2];
    assign dwdata     = dwdata_q;
    assign resp_valid = rv_q;
    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a word-addressed memory model
// and hand-computed expected responses, latencies and memory contents.
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        d_we;
    logic [6:0]  daddr;
    logic [31:0] dwdata;
    logic [31:0] drdata;

    logic [31:0] mem [128];
    logic        pre_we = 1'b0;
    logic [6:0]  pre_idx = 7'd0;
    logic [31:0] pre_dat = 32'h0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_dat;
        else if (d_we) mem[daddr] <= dwdata;
    end

    assign drdata = mem[daddr];

    lsu_rmw #(.ADDR_W(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .d_we       (d_we),
        .daddr      (daddr),
        .dwdata     (dwdata),
        .drdata     (drdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [6:0] idx, input logic [31:0] dat);
        @(negedge clk);
        pre_we  = 1'b1;
        pre_idx = idx;
        pre_dat = dat;
        @(negedge clk);
        pre_we  = 1'b0;
    endtask

    // Called on a negedge; that cycle is the request cycle 0.
    task automatic run(input string tag, input logic we,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int lat,
                       input logic exp_err, input logic [31:0] exp_rd,
                       input logic exp_wr, input logic [6:0] exp_da,
                       input logic [31:0] exp_dw);
        chk({tag, ".ready0"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(c == lat));
            chk({tag, ".ready"}, 32'(req_ready), 32'(c == lat));
            if (exp_wr && c == lat - 1) begin
                chk({tag, ".d_we"}, 32'(d_we), 32'd1);
                chk({tag, ".daddr"}, 32'(daddr), 32'(exp_da));
                chk({tag, ".dwdata"}, dwdata, exp_dw);
            end else begin
                chk({tag, ".no_we"}, 32'(d_we), 32'd0);
            end
        end
        chk({tag, ".err"}, 32'(resp_err), 32'(exp_err));
        chk({tag, ".rdata"}, resp_rdata, exp_rd);
    endtask

    initial begin
        #1;
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_err", 32'(resp_err), 32'd0);
        chk("rst.rdata", resp_rdata, 32'h0);
        chk("rst.d_we", 32'(d_we), 32'd0);
        chk("rst.daddr", 32'(daddr), 32'd0);
        chk("rst.dwdata", dwdata, 32'h0);

        preload(7'd5, 32'h8899_AABB);
        preload(7'd3, 32'h1122_3344);
        preload(7'd0, 32'h5A5A_5A5A);
        rst_n = 1'b1;
        @(negedge clk);

        run("lb", 0, 3'b000, 32'h16, 0, 2, 0, 32'hFFFF_FF99, 0, 0, 0);
        run("lbu", 0, 3'b100, 32'h16, 0, 2, 0, 32'h0000_0099, 0, 0, 0);
        run("lh", 0, 3'b001, 32'h14, 0, 2, 0, 32'hFFFF_AABB, 0, 0, 0);
        run("lhu", 0, 3'b101, 32'h16, 0, 2, 0, 32'h0000_8899, 0, 0, 0);
        run("lw", 0, 3'b010, 32'h14, 0, 2, 0, 32'h8899_AABB, 0, 0, 0);

        run("sb", 1, 3'b000, 32'h0D, 32'hDEAD_BEEF, 3, 0, 32'h0,
            1, 7'd3, 32'h1122_EF44);
        chk("sb.mem3", mem[3], 32'h1122_EF44);
        run("sh", 1, 3'b001, 32'h0E, 32'h0000_CAFE, 3, 0, 32'h0,
            1, 7'd3, 32'hCAFE_EF44);
        chk("sh.mem3", mem[3], 32'hCAFE_EF44);

        run("sw", 1, 3'b010, 32'h20, 32'h0BAD_F00D, 2, 0, 32'h0,
            1, 7'd8, 32'h0BAD_F00D);
        run("lw_b2b", 0, 3'b010, 32'h20, 0, 2, 0, 32'h0BAD_F00D, 0, 0, 0);

        run("lw_wrap", 0, 3'b010, 32'h8000_0214, 0, 2, 0,
            32'h8899_AABB, 0, 0, 0);

        run("lw_mis", 0, 3'b010, 32'h22, 0, 2, 1, 32'h0, 0, 0, 0);
        run("sh_mis", 1, 3'b001, 32'h03, 32'h1234_5678, 2, 1, 32'h0,
            0, 0, 0);
        run("f3_bad", 0, 3'b011, 32'h20, 0, 2, 1, 32'h0, 0, 0, 0);
        run("sbu_bad", 1, 3'b100, 32'h0C, 32'h77, 2, 1, 32'h0, 0, 0, 0);
        chk("err.mem8", mem[8], 32'h0BAD_F00D);
        chk("err.mem0", mem[0], 32'h5A5A_5A5A);
        chk("err.mem3", mem[3], 32'hCAFE_EF44);

        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h0D;
        req_wdata  = 32'h0000_0055;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid.in_read", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid.ready", 32'(req_ready), 32'd1);
        chk("mid.resp_valid", 32'(resp_valid), 32'd0);
        chk("mid.resp_err", 32'(resp_err), 32'd0);
        chk("mid.d_we", 32'(d_we), 32'd0);
        chk("mid.daddr", 32'(daddr), 32'd0);
        chk("mid.dwdata", dwdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid.no_resp", 32'(resp_valid), 32'd0);
            chk("mid.no_we", 32'(d_we), 32'd0);
        end
        chk("mid.mem3", mem[3], 32'hCAFE_EF44);
        chk("mid.ready_after", 32'(req_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
Load/store unit between the RV32I execute stage and the word-only data memory (7-bit word index, 32-bit write, combinational read, no byte enables). Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
- Loads: lane extraction plus sign/zero extension.
- Sub-word stores: read-modify-write sequence.
- Misaligned or unsupported accesses: reported as errors and never touch memory.

Parameters:
ADDR_W, 7, word-index width driven to memory; byte address bits [ADDR_W+1:2] select the word, higher bits are ignored.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present; sampled only when req_ready=1.
req_ready  out  1  high in IDLE only.
req_we  in  1  1=store, 0=load.
req_funct3  in  3  RV32I funct3 of the load/store.
req_addr  in  32  byte address.
req_wdata  in  32  rs2 value; stores use low byte/half/word.
resp_valid  out  1  one-cycle pulse, transaction complete.
resp_err  out  1  valid with resp_valid; misaligned or illegal funct3.
resp_rdata  out  32  extended load data; 0 for stores and errors.
d_we  out  1  memory write enable.
daddr  out  ADDR_W  memory word index.
dwdata  out  32  memory write data.
drdata  in  32  memory combinational read data.

Behaviour:
Reset (async, rst_n=0):
- state=IDLE; req_ready=1.
- resp_valid=0, resp_err=0, resp_rdata=0, d_we=0, daddr=0, dwdata=0.
- All latched request fields cleared.

States: IDLE, READ, WRITE, FAULT. d_we=1 only in WRITE, decoded from the state register.

IDLE:
- On req_valid, latch addr, funct3, we and wdata, then check legality:
  - Legal funct3: loads 000/001/010/100/101; stores 000/001/010.
  - Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
- Illegal or misaligned -> FAULT.
- SW -> WRITE, with dwdata=wdata.
- Other loads/stores -> READ.

READ:
- daddr comes from the latched address.
- Load: extract the lane from drdata by addr[1:0] (byte lanes 0..3, half lanes 0/2). Sign-extend for LB/LH; zero-extend for LBU/LHU; LW passes through. Register the result into resp_rdata, pulse resp_valid, go to IDLE.
- SB/SH: merge the wdata low byte/half into drdata at the lane and register it into dwdata. Go to WRITE.

WRITE:
- d_we=1 with daddr and dwdata from registers; memory commits at the edge leaving WRITE.
- resp_valid pulses the next cycle with resp_rdata=0 and resp_err=0. Go to IDLE.

FAULT:
- No memory access.
- resp_valid=1 and resp_err=1 the next cycle, resp_rdata=0. Go to IDLE.

Latency (request cycle = 0; resp_valid high in cycle N):
- Loads N=2, SW N=2, SB/SH N=3, error N=2.

Throughput and response:
- req_ready is high in the same cycle as resp_valid, so back-to-back requests are allowed.
- resp_* registers hold their values; only resp_valid is a pulse.

Boundaries:
- Request sampled only in IDLE; req_valid while busy is ignored, and the core must hold the request.
- daddr wraps modulo 2^ADDR_W.
- rst_n low mid-transaction (READ/WRITE): the transaction is dropped with no response. An async reset during WRITE deasserts d_we immediately, and the memory write does not occur if reset precedes the edge.
- Errors are evaluated before any memory access.

Decomposition:
- lsu_pkg:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - State enum lsu_state_t {IDLE, READ, WRITE, FAULT}.
- Sub-module lsu_align (combinational), used by lsu_rmw's READ path:
  - Inputs: word, offset[1:0], funct3, wdata.
  - Outputs: extended load value and merged store word.

Test Plan:
- Preload mem[5]=32'h8899_AABB; LB addr=0x16 -> resp_valid cycle 2, rdata=32'hFFFF_FF99; LBU same addr -> 32'h0000_0099.
- Preload mem[5]=32'h8899_AABB; LH addr=0x14 -> 32'hFFFF_AABB; LHU addr=0x16 -> 32'h0000_8899; LW addr=0x14 -> 32'h8899_AABB.
- mem[3]=32'h1122_3344; SB addr=0x0D wdata=32'hDEAD_BEEF -> READ, WRITE (d_we=1 one cycle, daddr=3), resp cycle 3; mem[3]=32'h1122_EF44. Then SH addr=0x0E wdata=32'h0000_CAFE -> mem[3]=32'hCAFE_EF44.
- SW addr=0x20 wdata=32'h0BAD_F00D -> d_we in cycle 1, daddr=8, resp cycle 2; back-to-back LW 0x20 accepted in cycle 2 -> rdata=32'h0BAD_F00D.
- LW addr=0x22, SH addr=0x03, funct3=3'b011 -> each gives resp_err=1 and rdata=0 in cycle 2; d_we never asserts and memory is unchanged.
- Assert rst_n=0 during the READ state of an SB -> all outputs reset immediately, no resp_valid, memory word unchanged, req_ready=1 after release.
